// File: rtl/jtag_debug_sysclk_dispatch.sv
// System-clock side of the JTAG debug module: synchronises update-IR/DR, latches jdo/ir_q, raises one-hot requests.
// Define DBG_ACK_HANDSHAKE_EN to hold each request until act_ack; otherwise requests are single-cycle pulses.
module jtag_debug_sysclk_dispatch #(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int ACT_BIT     = 35,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    localparam int NCH        = 2**IR_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vs_udr,
    input  logic             vs_uir,
    input  logic [IR_W-1:0]  ir_in,
    input  logic [DR_W-1:0]  sr,
    input  logic [NCH-1:0]   ch_en,
    input  logic [NCH-1:0]   act_ack,
    output logic [DR_W-1:0]  jdo,
    output logic [IR_W-1:0]  ir_q,
    output logic [NCH-1:0]   take_action,
    output logic [NCH-1:0]   take_no_action,
    output logic [CNT_W-1:0] upd_count,
    output logic             overrun,
    output logic             busy
);

    logic [SYNC_STAGES-1:0] udr_sync_q;
    logic [SYNC_STAGES-1:0] uir_sync_q;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   udr_edge_q;
    logic                   uir_edge_q;
    logic                   armed_q;
    logic [DR_W-1:0]        jdo_q;
    logic [IR_W-1:0]        ir_lat_q;
    logic [NCH-1:0]         act_q;
    logic [NCH-1:0]         noact_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   overrun_q;
    logic                   busy_q;

    logic                   udr_lvl;
    logic                   uir_lvl;
    logic                   udr_stb;
    logic                   uir_stb;
    logic [IR_W-1:0]        ch;
    logic [NCH-1:0]         ch_onehot;
    logic                   ack_hit;
    logic                   discard;
    logic                   accept;

    assign udr_lvl   = udr_sync_q[SYNC_STAGES-1];
    assign uir_lvl   = uir_sync_q[SYNC_STAGES-1];
    assign udr_stb   = armed_q & udr_lvl & ~udr_edge_q;
    assign uir_stb   = armed_q & uir_lvl & ~uir_edge_q;
    assign ch        = uir_stb ? ir_in : ir_lat_q;
    assign ch_onehot = NCH'(1) << ch;

`ifdef DBG_ACK_HANDSHAKE_EN
    assign ack_hit = |((act_q | noact_q) & act_ack);
    assign discard = udr_stb & busy_q & ~ack_hit;
`else
    // Pulse requests always retire after one cycle; the ack input has no role here.
    logic unused_ack;
    assign unused_ack = ^act_ack;
    assign ack_hit    = 1'b1;
    assign discard    = 1'b0;
`endif

    assign accept = udr_stb & ~discard & |(ch_en & ch_onehot);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync_q <= '0;
            uir_sync_q <= '0;
            prime_q    <= '0;
            udr_edge_q <= 1'b0;
            uir_edge_q <= 1'b0;
            armed_q    <= 1'b0;
            jdo_q      <= '0;
            ir_lat_q   <= '0;
            act_q      <= '0;
            noact_q    <= '0;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_edge_q <= udr_lvl;
            uir_edge_q <= uir_lvl;
            // Synchronised levels only mean something once the chain holds post-reset samples;
            // this keeps a level held high through reset release from looking like a fresh edge.
            prime_q    <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            if (prime_q[SYNC_STAGES-1] && !udr_lvl && !uir_lvl) begin
                armed_q <= 1'b1;
            end

            if (uir_stb) begin
                ir_lat_q <= ir_in;
            end
            if (ack_hit) begin
                act_q   <= '0;
                noact_q <= '0;
                busy_q  <= 1'b0;
            end
            if (accept) begin
                jdo_q   <= sr;
                cnt_q   <= cnt_q + CNT_W'(1);
                act_q   <= sr[ACT_BIT] ? ch_onehot : '0;
                noact_q <= sr[ACT_BIT] ? '0 : ch_onehot;
                busy_q  <= 1'b1;
            end
            if (discard) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign jdo            = jdo_q;
    assign ir_q           = ir_lat_q;
    assign take_action    = act_q;
    assign take_no_action = noact_q;
    assign upd_count      = cnt_q;
    assign overrun        = overrun_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_jtag_debug_sysclk_dispatch.sv
// Scoreboard bench for jtag_debug_sysclk_dispatch: stimulus pushes expected requests, a forked monitor pops them.
module tb_jtag_debug_sysclk_dispatch;
    localparam int IR_W = 2, DR_W = 38, ACT_BIT = 35, SYNC_STAGES = 2, CNT_W = 8, NCH = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             vs_udr, vs_uir;
    logic [IR_W-1:0]  ir_in;
    logic [DR_W-1:0]  sr;
    logic [NCH-1:0]   ch_en, act_ack;
    logic [DR_W-1:0]  jdo;
    logic [IR_W-1:0]  ir_q;
    logic [NCH-1:0]   take_action, take_no_action;
    logic [CNT_W-1:0] upd_count;
    logic             overrun, busy;

    jtag_debug_sysclk_dispatch #(
        .IR_W(IR_W), .DR_W(DR_W), .ACT_BIT(ACT_BIT), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
        .ch_en(ch_en), .act_ack(act_ack), .jdo(jdo), .ir_q(ir_q), .take_action(take_action),
        .take_no_action(take_no_action), .upd_count(upd_count), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NCH-1:0]   act;
        logic [NCH-1:0]   noact;
        logic [DR_W-1:0]  jdo;
        logic [CNT_W-1:0] cnt;
        int               due;
    } exp_t;

    exp_t             exp_q[$];
    int               errors = 0;
    int               checks = 0;
    logic [IR_W-1:0]  m_ir;
    logic [DR_W-1:0]  m_jdo;
    logic [CNT_W-1:0] m_cnt;
    bit               auto_ack;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [NCH-1:0] req, prev;
        logic           fresh;
        exp_t           e;
        prev = '0;
        forever begin
            @(negedge clk);
            req = take_action | take_no_action;
`ifdef DBG_ACK_HANDSHAKE_EN
            fresh = (prev == '0);
`else
            fresh = 1'b1;
`endif
            if (reset_n && req != '0 && fresh) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: act=%b no_act=%b, expected none", take_action, take_no_action);
                end else begin
                    e = exp_q.pop_front();
                    check("take_action", take_action, e.act);
                    check("take_no_action", take_no_action, e.noact);
                    check("jdo", jdo, e.jdo);
                    check("upd_count", upd_count, e.cnt);
                    check("busy_with_req", busy, 1);
                    check("req_cycle", cyc, e.due);
                end
            end
            prev = req;
        end
    endtask

`ifdef DBG_ACK_HANDSHAKE_EN
    task automatic acker();
        forever begin
            @(posedge clk);
            #2;
            if (auto_ack) act_ack = take_action | take_no_action;
        end
    endtask
`endif

    task automatic pulse_uir(input logic [IR_W-1:0] irv);
        ir_in  = irv;
        vs_uir = 1'b1;
        tick(4);
        vs_uir = 1'b0;
        tick(5);
        m_ir = irv;
        check("ir_q", ir_q, m_ir);
    endtask

    task automatic pulse_udr(input logic [DR_W-1:0] d, input bit with_uir,
                             input logic [IR_W-1:0] irv, input bit expect_discard);
        exp_t            e;
        logic [IR_W-1:0] ch;
        sr = d;
        ch = with_uir ? irv : m_ir;
        if (with_uir) begin
            ir_in = irv;
            m_ir  = irv;
        end
        if (!expect_discard && ch_en[ch]) begin
            m_jdo   = d;
            m_cnt   = m_cnt + 1'b1;
            e.act   = d[ACT_BIT] ? (4'b0001 << ch) : 4'b0000;
            e.noact = d[ACT_BIT] ? 4'b0000 : (4'b0001 << ch);
            e.jdo   = d;
            e.cnt   = m_cnt;
            e.due   = cyc + SYNC_STAGES + 1;
            exp_q.push_back(e);
        end
        vs_udr = 1'b1;
        if (with_uir) vs_uir = 1'b1;
        tick(4);
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        tick(5);
    endtask

    task automatic check_idle(input string name);
        check({name, "_req_idle"}, take_action | take_no_action, 0);
        check({name, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; vs_udr = 1'b1; vs_uir = 1'b0; ir_in = '0; sr = '0;
        ch_en = '1; act_ack = '0; auto_ack = 1'b1;
        m_ir = '0; m_jdo = '0; m_cnt = '0;
        fork monitor(); join_none
`ifdef DBG_ACK_HANDSHAKE_EN
        fork acker(); join_none
`endif
        tick(3);
        check("rst_jdo", jdo, 0);
        check("rst_ir_q", ir_q, 0);
        check("rst_take_action", take_action, 0);
        check("rst_take_no_action", take_no_action, 0);
        check("rst_upd_count", upd_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);

        // vs_udr held high through reset release: no strobe, no count
        reset_n = 1'b1;
        tick(8);
        check("held_high_count", upd_count, 0);
        vs_udr = 1'b0;
        tick(6);
        pulse_udr(38'h00_0000_0001, 1'b0, '0, 1'b0);
        check("first_edge_count", upd_count, 1);
        check_idle("t1");

        pulse_uir(2'd1);
        pulse_udr(38'h8_DEAD_BEEF, 1'b0, '0, 1'b0);
        check_idle("t2");

        // masked channel: update dropped
        pulse_uir(2'd3);
        ch_en = 4'b0111;
        pulse_udr(38'h3_0000_0003, 1'b0, '0, 1'b0);
        check("masked_jdo", jdo, m_jdo);
        check("masked_count", upd_count, m_cnt);
        check_idle("t3");
        ch_en = 4'b1111;

        // simultaneous uir+udr: new IR selects the channel
        pulse_udr(38'h0_1111_2222, 1'b1, 2'd0, 1'b0);
        check("same_cycle_ir_q", ir_q, 0);
        pulse_udr(38'h3F_FFFF_FFFF, 1'b1, 2'd3, 1'b0);
        check("same_cycle_ir_q3", ir_q, 3);
        check_idle("t4");

        // counter wrap through 255 -> 0 -> 1
        for (int i = 0; i < 256; i++) begin
            pulse_udr({2'b00, i[0], 3'b000, 32'(i) * 32'h0101_0101}, 1'b0, '0, 1'b0);
        end
        check("wrap_count", upd_count, m_cnt);
        check_idle("t5");

`ifdef DBG_ACK_HANDSHAKE_EN
        auto_ack = 1'b0;
        pulse_uir(2'd2);
        pulse_udr(38'h8_1234_5678, 1'b0, '0, 1'b0);
        check("hs_busy_held", busy, 1);
        check("hs_req_held", take_action, 4'b0100);
        pulse_udr(38'h0_0BAD_F00D, 1'b0, '0, 1'b1);
        check("hs_overrun", overrun, 1);
        check("hs_jdo_kept", jdo, m_jdo);
        check("hs_count_kept", upd_count, m_cnt);
        act_ack = 4'b0100;
        tick(1);
        act_ack = 4'b0000;
        check("hs_req_dropped", take_action, 0);
        check("hs_busy_dropped", busy, 0);
        check("hs_overrun_sticky", overrun, 1);
        auto_ack = 1'b1;
`else
        check("overrun_zero", overrun, 0);
`endif

        // reset asserted while a request is being raised
        sr = 38'h8_5555_AAAA;
        vs_udr = 1'b1;
        tick(SYNC_STAGES + 1);
        reset_n = 1'b0;
        #1;
        check("midrst_req", take_action | take_no_action, 0);
        check("midrst_jdo", jdo, 0);
        check("midrst_count", upd_count, 0);
        check("midrst_busy", busy, 0);
        vs_udr = 1'b0;
        m_ir = '0; m_jdo = '0; m_cnt = '0;
        tick(2);
        reset_n = 1'b1;
        tick(6);
        pulse_udr(38'h0_0000_0042, 1'b0, '0, 1'b0);
        check("post_rst_count", upd_count, 1);

        tick(4);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
